// File: rtl/cpumc_arb.sv
// cpumc_arb: shares the single cpumc memory bus between the 6502 CPU port and the
// debug/loader port. Every access walks IDLE -> ISSUE -> CAPTURE. The owner's ack and
// read data appear in the cycle after CAPTURE, because the PRG-ROM block RAM returns
// data one clock after it sees the address.
module cpumc_arb #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int DBG_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_wr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_din,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_dout,
    input  logic                  dbg_req,
    input  logic                  dbg_wr,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_din,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] dbg_dout,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    logic [1:0]            state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;
    logic                  wr_q, wr_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic                  dbg_ack_q, dbg_ack_d;
    logic [DATA_WIDTH-1:0] cpu_dout_q, cpu_dout_d;
    logic [DATA_WIDTH-1:0] dbg_dout_q, dbg_dout_d;
    logic                  cpu_elig, dbg_elig, grant_dbg;

    // Choose the winner among eligible ports; a port being acked this cycle sits out.
    always_comb begin
        cpu_elig = cpu_req & ~cpu_ack_q;
        dbg_elig = dbg_req & ~dbg_ack_q;
        if (cpu_elig && dbg_elig) begin
            if (DBG_PRIORITY != 0) begin
                grant_dbg = 1'b1;
            end else begin
                grant_dbg = (last_grant_q == OWN_CPU);
            end
        end else begin
            grant_dbg = dbg_elig;
        end
    end

    // Sequence one access: latch the winner, pulse the write, then capture the read data.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        mem_wr_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        cpu_ack_d    = 1'b0;
        dbg_ack_d    = 1'b0;
        cpu_dout_d   = cpu_dout_q;
        dbg_dout_d   = dbg_dout_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_elig || dbg_elig) begin
                    owner_d    = grant_dbg ? OWN_DBG : OWN_CPU;
                    wr_d       = grant_dbg ? dbg_wr : cpu_wr;
                    mem_wr_d   = grant_dbg ? dbg_wr : cpu_wr;
                    mem_addr_d = grant_dbg ? dbg_addr : cpu_addr;
                    mem_din_d  = grant_dbg ? dbg_din : cpu_din;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d      = ST_IDLE;
                last_grant_d = owner_q;
                if (owner_q == OWN_DBG) begin
                    dbg_ack_d = 1'b1;
                    if (!wr_q) begin
                        dbg_dout_d = mem_dout;
                    end
                end else begin
                    cpu_ack_d = 1'b1;
                    if (!wr_q) begin
                        cpu_dout_d = mem_dout;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset leaves DBG as last grant so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_CPU;
            last_grant_q <= OWN_DBG;
            wr_q         <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            cpu_ack_q    <= 1'b0;
            dbg_ack_q    <= 1'b0;
            cpu_dout_q   <= '0;
            dbg_dout_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            cpu_ack_q    <= cpu_ack_d;
            dbg_ack_q    <= dbg_ack_d;
            cpu_dout_q   <= cpu_dout_d;
            dbg_dout_q   <= dbg_dout_d;
        end
    end

    assign mem_wr   = mem_wr_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign cpu_ack  = cpu_ack_q;
    assign dbg_ack  = dbg_ack_q;
    assign cpu_dout = cpu_dout_q;
    assign dbg_dout = dbg_dout_q;

endmodule

// File: tb/tb_cpumc_arb.sv
// tb_cpumc_arb: drives two arbiter instances (round-robin and DBG-priority) with the same
// requester stimulus. Each instance gets its own cpumc memory model, reference model and
// scoreboard monitor.
module tb_cpumc_arb;

    typedef struct {
        int         cyc;
        int         port;
        logic [7:0] data;
    } ack_t;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_wr = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic [7:0]  cpu_din = 8'h0;
    logic        dbg_req = 1'b0, dbg_wr = 1'b0;
    logic [15:0] dbg_addr = 16'h0;
    logic [7:0]  dbg_din = 8'h0;

    logic [1:0]  cpu_ack_w, dbg_ack_w, mem_wr_w;
    logic [15:0] mem_addr_w [2];
    logic [7:0]  mem_din_w [2];
    logic [7:0]  cpu_dout_w [2];
    logic [7:0]  dbg_dout_w [2];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    bit done = 1'b0;
    int done_cnt = 0;

    // 50MHz system clock
    always #10 clk = ~clk;

    // Cycle stamp: during cycle n (between posedges) cyc holds n
    always @(posedge clk) cyc <= cyc + 1;

    // cpumc leaves 0x1000-0x7FFF unmapped: reads return 0, writes are dropped
    function automatic bit isMapped(input logic [15:0] a);
        return !(a >= 16'h1000 && a < 16'h8000);
    endfunction

    function automatic logic [15:0] pickAddr();
        logic [15:0] base;
        case ($urandom_range(0, 3))
            0:       base = 16'h0000;
            1:       base = 16'h1000;
            2:       base = 16'h8000;
            default: base = 16'hC120;
        endcase
        return base + 16'($urandom_range(0, 7));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_inst
        logic        cpu_ack_l, dbg_ack_l, mem_wr_l;
        logic [7:0]  cpu_dout_l, dbg_dout_l, mem_din_l, mem_dout_l;
        logic [15:0] mem_addr_l;
        logic [7:0]  ram [0:65535];
        logic [7:0]  ref_mem [0:65535];
        ack_t        exp_ack [$];
        wr_t         exp_wr [$];

        cpumc_arb #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .DBG_PRIORITY(k)) dut (
            .clk(clk), .rst(rst),
            .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
            .cpu_ack(cpu_ack_l), .cpu_dout(cpu_dout_l),
            .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_din(dbg_din),
            .dbg_ack(dbg_ack_l), .dbg_dout(dbg_dout_l),
            .mem_wr(mem_wr_l), .mem_addr(mem_addr_l), .mem_din(mem_din_l), .mem_dout(mem_dout_l)
        );

        assign cpu_ack_w[k]  = cpu_ack_l;
        assign dbg_ack_w[k]  = dbg_ack_l;
        assign mem_wr_w[k]   = mem_wr_l;
        assign mem_addr_w[k] = mem_addr_l;
        assign mem_din_w[k]  = mem_din_l;
        assign cpu_dout_w[k] = cpu_dout_l;
        assign dbg_dout_w[k] = dbg_dout_l;

        initial begin
            for (int i = 0; i < 65536; i++) begin
                ram[i]     = 8'h00;
                ref_mem[i] = 8'h00;
            end
        end

        // cpumc stand-in: synchronous RAM, read data one clock after the address
        always @(posedge clk) begin
            if (mem_wr_l && isMapped(mem_addr_l)) ram[mem_addr_l] <= mem_din_l;
            mem_dout_l <= isMapped(mem_addr_l) ? ram[mem_addr_l] : 8'h00;
        end

        // Reference model: a grant in cycle g writes in g+1, acks in g+3 and frees the bus at g+3
        int          free_c = 0;
        int          last_g = 1;
        int          ack_c [2] = '{-1, -1};
        logic [7:0]  last_dout [2] = '{8'h00, 8'h00};
        bit          pw_v = 1'b0, pa_v = 1'b0;
        int          pw_c, pa_c, pa_p;
        bit          pa_wr;
        logic [15:0] pw_a, pa_a;
        logic [7:0]  pw_d;

        always @(posedge clk) begin : model
            int         c, n, p;
            bit         ce, de, w;
            logic [7:0] d;
            c = cyc;
            n = c + 1;
            if (rst) begin
                pw_v = 1'b0;
                pa_v = 1'b0;
                free_c = n;
                last_g = 1;
                ack_c = '{-1, -1};
                last_dout = '{8'h00, 8'h00};
            end else begin
                ce = cpu_req && (ack_c[0] != c);
                de = dbg_req && (ack_c[1] != c);
                if (c >= free_c && (ce || de)) begin
                    if (ce && de) p = (k == 1) ? 1 : 1 - last_g;
                    else          p = de ? 1 : 0;
                    w = (p == 1) ? dbg_wr : cpu_wr;
                    if (w) begin
                        pw_v = 1'b1;
                        pw_c = n;
                        pw_a = (p == 1) ? dbg_addr : cpu_addr;
                        pw_d = (p == 1) ? dbg_din : cpu_din;
                    end
                    pa_v   = 1'b1;
                    pa_c   = c + 3;
                    pa_p   = p;
                    pa_wr  = w;
                    pa_a   = (p == 1) ? dbg_addr : cpu_addr;
                    free_c = c + 3;
                    last_g = p;
                end
                if (pw_v && pw_c == n) begin
                    exp_wr.push_back('{n, pw_a, pw_d});
                    if (isMapped(pw_a)) ref_mem[pw_a] = pw_d;
                    pw_v = 1'b0;
                end
                if (pa_v && pa_c == n) begin
                    if (pa_wr) d = last_dout[pa_p];
                    else       d = isMapped(pa_a) ? ref_mem[pa_a] : 8'h00;
                    last_dout[pa_p] = d;
                    ack_c[pa_p] = n;
                    exp_ack.push_back('{n, pa_p, d});
                    pa_v = 1'b0;
                end
            end
        end

        // Scoreboard monitor: pops one expectation per ack or write pulse the DUT presents
        always @(negedge clk) begin : monitor
            ack_t       e;
            wr_t        ew;
            logic [1:0] acks;
            logic [7:0] douts [2];
            if (cyc >= 1) begin
                acks = {dbg_ack_l, cpu_ack_l};
                douts[0] = cpu_dout_l;
                douts[1] = dbg_dout_l;
                checkOutput($sformatf("i%0d_ack_exclusive", k), 32'(cpu_ack_l & dbg_ack_l), 0);
                for (int p = 0; p < 2; p++) begin
                    if (acks[p]) begin
                        if (exp_ack.size() == 0) begin
                            checkOutput($sformatf("i%0d_p%0d_unexpected_ack", k, p), 1, 0);
                        end else begin
                            e = exp_ack.pop_front();
                            checkOutput($sformatf("i%0d_ack_port", k), p, e.port);
                            checkOutput($sformatf("i%0d_ack_cycle", k), cyc, e.cyc);
                            checkOutput($sformatf("i%0d_p%0d_dout", k, p), douts[p], e.data);
                        end
                    end
                end
                if (mem_wr_l) begin
                    if (exp_wr.size() == 0) begin
                        checkOutput($sformatf("i%0d_unexpected_mem_wr", k), 1, 0);
                    end else begin
                        ew = exp_wr.pop_front();
                        checkOutput($sformatf("i%0d_wr_cycle", k), cyc, ew.cyc);
                        checkOutput($sformatf("i%0d_wr_addr", k), mem_addr_l, ew.addr);
                        checkOutput($sformatf("i%0d_wr_data", k), mem_din_l, ew.data);
                    end
                end
            end
        end

        // Every expected ack and write must have been seen by the end
        initial begin
            wait (done);
            checkOutput($sformatf("i%0d_acks_left", k), exp_ack.size(), 0);
            checkOutput($sformatf("i%0d_writes_left", k), exp_wr.size(), 0);
            done_cnt++;
        end
    end

    // All outputs of both instances must sit at their reset values
    task automatic resetCheck(input string tag);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("%s_i%0d_cpu_ack", tag, k), cpu_ack_w[k], 0);
            checkOutput($sformatf("%s_i%0d_dbg_ack", tag, k), dbg_ack_w[k], 0);
            checkOutput($sformatf("%s_i%0d_mem_wr", tag, k), mem_wr_w[k], 0);
            checkOutput($sformatf("%s_i%0d_mem_addr", tag, k), mem_addr_w[k], 0);
            checkOutput($sformatf("%s_i%0d_mem_din", tag, k), mem_din_w[k], 0);
            checkOutput($sformatf("%s_i%0d_cpu_dout", tag, k), cpu_dout_w[k], 0);
            checkOutput($sformatf("%s_i%0d_dbg_dout", tag, k), dbg_dout_w[k], 0);
        end
    endtask

    // Issue one access on a port and hold it until instance 0 acks (bounded wait)
    task automatic applyStimulus(input int port, input bit wr, input logic [15:0] a,
                                 input logic [7:0] d, input bit keep);
        bit got;
        got = 1'b0;
        if (port == 0) begin
            cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_din = d;
        end else begin
            dbg_req = 1'b1; dbg_wr = wr; dbg_addr = a; dbg_din = d;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (port == 0) ? cpu_ack_w[0] : dbg_ack_w[0];
        end
        checkOutput($sformatf("p%0d_ack_arrived", port), 32'(got), 1);
        if (!keep) begin
            if (port == 0) cpu_req = 1'b0;
            else           dbg_req = 1'b0;
        end
    endtask

    // Directed scenarios followed by a randomized soak
    initial begin
        bit seen;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        resetCheck("reset");
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(0, 1'b1, 16'hC123, 8'hA5, 1'b0);
        applyStimulus(0, 1'b0, 16'hC123, 8'h00, 1'b0);
        checkOutput("cpu_readback_C123", cpu_dout_w[0], 8'hA5);
        applyStimulus(0, 1'b0, 16'h1000, 8'h00, 1'b0);
        checkOutput("cpu_read_unmapped", cpu_dout_w[0], 8'h00);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1'b1, 16'h8000 + 16'(i), 8'h10 + 8'(i), i < 3);
        end
        applyStimulus(1, 1'b0, 16'h8002, 8'h00, 1'b0);
        checkOutput("dbg_readback_8002", dbg_dout_w[0], 8'h12);

        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h8001;
        dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 16'h8003;
        repeat (24) @(negedge clk);
        dbg_req = 1'b0;
        repeat (12) @(negedge clk);
        cpu_req = 1'b0;
        repeat (4) @(negedge clk);

        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 16'h8010; dbg_din = 8'h5A;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = mem_wr_w[0];
        end
        checkOutput("dbg_write_issued", 32'(seen), 1);
        rst = 1'b1;
        dbg_req = 1'b0;
        @(negedge clk);
        resetCheck("midreset");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        applyStimulus(1, 1'b0, 16'h8010, 8'h00, 1'b0);
        checkOutput("dbg_read_after_abort", dbg_dout_w[0], 8'h5A);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 99) == 0);
            cpu_req  = ($urandom_range(0, 9) < 6);
            cpu_wr   = $urandom_range(0, 1) == 1;
            cpu_addr = pickAddr();
            cpu_din  = 8'($urandom);
            dbg_req  = ($urandom_range(0, 9) < 5);
            dbg_wr   = $urandom_range(0, 1) == 1;
            dbg_addr = pickAddr();
            dbg_din  = 8'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        repeat (10) @(negedge clk);

        done = 1'b1;
        wait (done_cnt == 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
